// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t      : receiver FSM state encoding
//   DATA_BITS       : payload bits per frame
//   STOP_BITS       : stop bits per frame
//   ADDR_RX_*       : register addresses used by the peripheral wrapper
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BRK   = 3'd4
   } rx_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   localparam logic [31:0] ADDR_RX_DATA   = 32'h4000_0018;
   localparam logic [31:0] ADDR_RX_STATUS = 32'h4000_001C;
   localparam logic [31:0] ADDR_RX_CTRL   = 32'h4000_0020;

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO for the UART receiver.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write wdata (accepted when not full, or when full and popping)
//   pop        : drop the head entry (ignored when empty)
//   wdata      : byte to store
//   rdata      : current head, 0 when empty
//   full/empty : occupancy flags
//   count      : number of stored entries
module uart_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra bit so that full and empty are distinct; the
   // low AW bits address the storage and wrap modulo DEPTH.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // When full, a simultaneous pop frees the head slot, which is the slot
   // being written.
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with show-ahead receive FIFO.
//   sys_clk   : sole clock
//   reset     : asynchronous active-high reset
//   uart_rx   : serial line (idle high, asynchronous)
//   rd_en     : pop the FIFO head
//   clr_err   : clear sticky frame_err / overrun
//   rx_data   : FIFO head byte (0 when empty)
//   rx_valid  : FIFO not empty
//   rx_count  : FIFO occupancy
//   rx_busy   : frame in progress
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, good byte dropped on a full FIFO
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge (only once armed)
// ST_START | timing to mid start bit to reject glitches
// ST_DATA  | sampling 8 data bits at bit centres, LSB first
// ST_STOP  | sampling stop bit; push, drop (overrun) or flag framing
// ST_BRK   | stop bit was low; waiting for the line to return high
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          sys_clk,
   input  logic                          reset,
   input  logic                          uart_rx,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          rx_busy,
   output logic                          frame_err,
   output logic                          overrun
);

   localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [TW-1:0] T_MID    = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   logic                 sync1;
   logic                 rxs;
   logic [1:0]           sync_fill;
   logic                 armed;
   logic [DW-1:0]        div_cnt;
   logic                 tick;
   rx_state_t            state;
   logic [TW-1:0]        tcnt;
   logic [BW-1:0]        bitn;
   logic [DATA_BITS-1:0] shreg;
   logic                 start_det;
   logic                 stop_sample;
   logic                 fifo_push;
   logic                 byte_drop;
   logic                 fifo_full;
   logic                 fifo_empty;

   // Sync flops preset high (idle line). sync_fill tracks when rxs holds a
   // real line sample rather than the preset, so arming cannot be fooled by
   // the preset value while the line is actually low after reset.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         sync1     <= 1'b1;
         rxs       <= 1'b1;
      end else begin
         sync1     <= uart_rx;
         rxs       <= sync1;
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         sync_fill <= 2'b00;
         armed     <= 1'b0;
      end else begin
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && rxs) begin
            armed <= 1'b1;
         end
      end
   end

   assign start_det = (state == ST_IDLE) && armed && !rxs;
   assign tick      = (div_cnt == DIV_LAST);

   // Restarting the divider on start detect aligns tick phase to the frame.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (start_det || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign stop_sample = (state == ST_STOP) && tick && (tcnt == T_LAST);
   assign fifo_push   = stop_sample && rxs && (!fifo_full || rd_en);
   assign byte_drop   = stop_sample && rxs && fifo_full && !rd_en;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         tcnt      <= '0;
         bitn      <= '0;
         shreg     <= '0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // Clear first so a same-cycle set below takes precedence.
         if (clr_err) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (start_det) begin
                  state   <= ST_START;
                  tcnt    <= '0;
                  rx_busy <= 1'b1;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (tcnt == T_MID) begin
                     if (!rxs) begin
                        state <= ST_DATA;
                        tcnt  <= '0;
                        bitn  <= '0;
                     end else begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                     end
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (tcnt == T_LAST) begin
                     tcnt  <= '0;
                     shreg <= {rxs, shreg[DATA_BITS-1:1]};
                     if (bitn == BIT_LAST) begin
                        state <= ST_STOP;
                     end else begin
                        bitn <= bitn + 1'b1;
                     end
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (tcnt == T_LAST) begin
                     tcnt <= '0;
                     if (rxs) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                        if (byte_drop) begin
                           overrun <= 1'b1;
                        end
                     end else begin
                        state     <= ST_BRK;
                        frame_err <= 1'b1;
                     end
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            ST_BRK: begin
               if (rxs) begin
                  state   <= ST_IDLE;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk   (sys_clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (rd_en),
      .wdata (shreg),
      .rdata (rx_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (rx_count)
   );

   assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIV=10, 160 clocks per bit.
module tb_uart_rx_fifo;

   localparam int CLK_HZ   = 1600000;
   localparam int BAUD     = 10000;
   localparam int OS       = 16;
   localparam int DEPTH    = 4;
   localparam int BIT_CLKS = 160;
   // Line falls just after edge E0; push lands on edge E1523.
   localparam int PUSH_CYC = 1522;

   logic       sys_clk = 1'b0;
   logic       reset   = 1'b1;
   logic       uart_rx = 1'b1;
   logic       rd_en   = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [2:0] rx_count;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] d;
      int         pop_cyc;
      logic [7:0] head;
      int         count;
      logic       ovr;
   } vec_t;

   vec_t vecs[10];
   logic vp, vq;

   uart_rx_fifo #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OS),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .sys_clk   (sys_clk),
      .reset     (reset),
      .uart_rx   (uart_rx),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_count  (rx_count),
      .rx_busy   (rx_busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_cyc,
                             output logic v_pre, output logic v_post);
      v_pre  = 1'b0;
      v_post = 1'b0;
      for (int c = 0; c < 10 * BIT_CLKS; c++) begin
         int b;
         b = c / BIT_CLKS;
         if (b == 0)      uart_rx = 1'b0;
         else if (b <= 8) uart_rx = d[b-1];
         else             uart_rx = stop;
         rd_en = (c == pop_cyc);
         if (c == PUSH_CYC)     v_pre  = rx_valid;
         if (c == PUSH_CYC + 1) v_post = rx_valid;
         @(posedge sys_clk);
         #1;
      end
      rd_en = 1'b0;
   endtask

   task automatic pop_expect(input string name, input logic [7:0] e);
      check({name, "_valid"}, rx_valid, 1);
      check({name, "_data"}, rx_data, e);
      rd_en = 1'b1;
      cycles(1);
      rd_en = 1'b0;
   endtask

   task automatic check_empty(input string name);
      check({name, "_valid"}, rx_valid, 0);
      check({name, "_data"}, rx_data, 0);
      check({name, "_count"}, rx_count, 0);
   endtask

   task automatic run_vec(input int i);
      logic a, b;
      send_frame(vecs[i].d, 1'b1, vecs[i].pop_cyc, a, b);
      check($sformatf("vec%0d_head", i), rx_data, vecs[i].head);
      check($sformatf("vec%0d_count", i), rx_count, vecs[i].count);
      check($sformatf("vec%0d_overrun", i), overrun, vecs[i].ovr);
      check($sformatf("vec%0d_ferr", i), frame_err, 0);
      check($sformatf("vec%0d_busy", i), rx_busy, 0);
   endtask

   initial begin
      // Back-to-back fill and overrun, then the same with a pop on the 5th push.
      vecs[0] = '{8'h00, -1,       8'h00, 1, 1'b0};
      vecs[1] = '{8'hFF, -1,       8'h00, 2, 1'b0};
      vecs[2] = '{8'h81, -1,       8'h00, 3, 1'b0};
      vecs[3] = '{8'h3C, -1,       8'h00, 4, 1'b0};
      vecs[4] = '{8'h11, -1,       8'h00, 4, 1'b1};
      vecs[5] = '{8'h00, -1,       8'h00, 1, 1'b0};
      vecs[6] = '{8'hFF, -1,       8'h00, 2, 1'b0};
      vecs[7] = '{8'h81, -1,       8'h00, 3, 1'b0};
      vecs[8] = '{8'h3C, -1,       8'h00, 4, 1'b0};
      vecs[9] = '{8'h11, PUSH_CYC, 8'hFF, 4, 1'b0};

      cycles(3);
      check_empty("rst");
      check("rst_busy", rx_busy, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      reset = 1'b0;
      cycles(5);

      // Good frame with exact push latency.
      send_frame(8'h5A, 1'b1, -1, vp, vq);
      check("s1_valid_before_push", vp, 0);
      check("s1_valid_after_push", vq, 1);
      check("s1_data", rx_data, 8'h5A);
      check("s1_count", rx_count, 1);
      check("s1_ferr", frame_err, 0);
      check("s1_ovr", overrun, 0);
      rd_en = 1'b1;
      cycles(1);
      rd_en = 1'b0;
      check_empty("s1_pop");

      for (int i = 0; i < 5; i++) run_vec(i);
      pop_expect("s2_h0", 8'h00);
      pop_expect("s2_h1", 8'hFF);
      pop_expect("s2_h2", 8'h81);
      pop_expect("s2_h3", 8'h3C);
      check_empty("s2_drain");
      check("s2_ovr_held", overrun, 1);
      clr_err = 1'b1;
      cycles(1);
      clr_err = 1'b0;
      check("s2_ovr_clr", overrun, 0);

      for (int i = 5; i < 10; i++) run_vec(i);
      pop_expect("s3_h0", 8'hFF);
      pop_expect("s3_h1", 8'h81);
      pop_expect("s3_h2", 8'h3C);
      pop_expect("s3_h3", 8'h11);
      check_empty("s3_drain");

      // Glitch shorter than half a bit.
      uart_rx = 1'b0;
      cycles(30);
      check("s4_busy_glitch", rx_busy, 1);
      cycles(30);
      uart_rx = 1'b1;
      cycles(60);
      check("s4_busy_drop", rx_busy, 0);
      check_empty("s4_nopush");
      check("s4_ferr", frame_err, 0);
      send_frame(8'hA5, 1'b1, -1, vp, vq);
      check("s4_data", rx_data, 8'hA5);
      check("s4_count", rx_count, 1);
      pop_expect("s4_pop", 8'hA5);

      // Framing error followed by a break.
      send_frame(8'h33, 1'b0, -1, vp, vq);
      check("s5_ferr", frame_err, 1);
      check("s5_count", rx_count, 0);
      check("s5_busy_brk", rx_busy, 1);
      cycles(399);
      check("s5_busy_brk_late", rx_busy, 1);
      uart_rx = 1'b1;
      cycles(5);
      check("s5_busy_end", rx_busy, 0);
      check("s5_ferr_sticky", frame_err, 1);
      clr_err = 1'b1;
      cycles(1);
      clr_err = 1'b0;
      check("s5_ferr_clr", frame_err, 0);
      send_frame(8'h7E, 1'b1, -1, vp, vq);
      check("s5_data", rx_data, 8'h7E);
      check("s5_count", rx_count, 1);
      pop_expect("s5_pop", 8'h7E);

      // Reset during bit 4 of frame 0x0F with two bytes buffered.
      send_frame(8'h12, 1'b1, -1, vp, vq);
      send_frame(8'h34, 1'b1, -1, vp, vq);
      check("s6_count2", rx_count, 2);
      uart_rx = 1'b0;
      cycles(BIT_CLKS);
      uart_rx = 1'b1;
      cycles(4 * BIT_CLKS);
      uart_rx = 1'b0;
      cycles(BIT_CLKS / 2);
      check("s6_busy_mid", rx_busy, 1);
      reset = 1'b1;
      #1;
      check_empty("s6_rst");
      check("s6_rst_busy", rx_busy, 0);
      check("s6_rst_ferr", frame_err, 0);
      check("s6_rst_ovr", overrun, 0);
      cycles(4);
      reset = 1'b0;
      cycles(300);
      check("s6_unarmed_busy", rx_busy, 0);
      cycles(256);
      uart_rx = 1'b1;
      cycles(BIT_CLKS);
      check("s6_after_busy", rx_busy, 0);
      check_empty("s6_after");
      check("s6_after_ferr", frame_err, 0);
      send_frame(8'hC3, 1'b1, -1, vp, vq);
      check("s6_data", rx_data, 8'hC3);
      check("s6_count", rx_count, 1);
      pop_expect("s6_pop", 8'hC3);
      check_empty("s6_final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
